// File: rtl/rv32i_branch_ctrl_pkg.sv
// Shared definitions for the rv32i branch/jump resolution slice:
// funct3 branch codes, controller FSM states and the condition-result payload.
package rv32i_branch_ctrl_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic taken;
    logic illegal;
  } cond_res_t;

  // funct3 010/011 are not branch encodings
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/rv32i_branch_ctrl_if.sv
// PC redirect channel from the branch controller to fetch (valid/ready).
interface rv32i_branch_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            valid;
  logic [XLEN-1:0] pc;
  logic            ready;

  modport master (output valid, output pc, input ready);
  modport slave  (input valid, input pc, output ready);

endinterface

// File: rtl/rv32i_branch_ctrl_cond.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
module rv32i_branch_ctrl_cond
  import rv32i_branch_ctrl_pkg::*;
(
  input  logic      [2:0] funct3_i,
  input  logic            equal_i,
  input  logic            less_i,
  input  logic            less_signed_i,
  output cond_res_t       cond_c_o
);

  always_comb begin
    cond_c_o         = '0;
    cond_c_o.illegal = f3_is_illegal(funct3_i);
    case (funct3_i)
      F3_BEQ:  cond_c_o.taken = equal_i;
      F3_BNE:  cond_c_o.taken = ~equal_i;
      F3_BLT:  cond_c_o.taken = less_signed_i;
      F3_BGE:  cond_c_o.taken = ~less_signed_i;
      F3_BLTU: cond_c_o.taken = less_i;
      F3_BGEU: cond_c_o.taken = ~less_i;
      default: cond_c_o.taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_branch_ctrl.sv
// ALU-stage branch/JAL/JALR resolution: issues a PC redirect to fetch, then
// holds the upstream clear for a fixed flush window (static not-taken).
module rv32i_branch_ctrl
  import rv32i_branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 branch_i,
  input  logic                 jal_i,
  input  logic                 jalr_i,
  input  logic [2:0]           funct3_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic                 equal_i,
  input  logic                 less_i,
  input  logic                 less_signed_i,
  rv32i_branch_ctrl_if.master  redirect_if,
  output logic                 clear_o,
  output logic                 busy_o,
  output logic                 misalign_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     branch_cnt_o,
  output logic [CNT_W-1:0]     redirect_cnt_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e            state_q;
  logic [FC_W-1:0]   flush_q;
  logic              rv_q;
  logic [XLEN-1:0]   pc_q;
  logic              clear_q;
  logic              busy_q;
  logic              misalign_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  cond_res_t         cond;
  logic              is_br;
  logic              take;
  logic              accept;
  logic              handshake;
  logic [XLEN-1:0]   target;

  rv32i_branch_ctrl_cond u_cond (
    .funct3_i      (funct3_i),
    .equal_i       (equal_i),
    .less_i        (less_i),
    .less_signed_i (less_signed_i),
    .cond_c_o      (cond)
  );

  // Type priority jalr > jal > branch; a branch flag under a jump is not a branch.
  always_comb begin
    is_br     = branch_i & ~jal_i & ~jalr_i;
    take      = jalr_i | jal_i | (is_br & cond.taken);
    target    = jalr_i ? (alu_result_i & ~XLEN'(1)) : (pc_i + imm_i);
    accept    = (state_q == ST_IDLE) & valid_i;
    handshake = (state_q == ST_REDIRECT) & redirect_if.ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      flush_q    <= '0;
      rv_q       <= 1'b0;
      pc_q       <= '0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            illegal_q <= is_br & cond.illegal;
            if (take) begin
              // Half-word aligned target cannot be fetched: flag it, stay put
              if (target[1]) begin
                misalign_q <= 1'b1;
              end else begin
                rv_q    <= 1'b1;
                pc_q    <= target;
                clear_q <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= ST_REDIRECT;
              end
            end
          end
        end
        ST_REDIRECT: begin
          if (handshake) begin
            rv_q    <= 1'b0;
            flush_q <= FC_LOAD;
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_q == '0) begin
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            flush_q <= flush_q - FC_W'(1);
          end
        end
        default: begin
          rv_q    <= 1'b0;
          clear_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Performance counters, free-running with natural wrap
  always_comb begin
    branch_cnt_d   = branch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (accept && is_br) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (handshake) begin
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      branch_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      branch_cnt_q   <= branch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign redirect_if.valid = rv_q;
  assign redirect_if.pc    = pc_q;
  assign clear_o           = clear_q;
  assign busy_o            = busy_q;
  assign misalign_o        = misalign_q;
  assign illegal_o         = illegal_q;
  assign branch_cnt_o      = branch_cnt_q;
  assign redirect_cnt_o    = redirect_cnt_q;

endmodule

// File: tb/tb_rv32i_branch_ctrl.sv
// Bench for rv32i_branch_ctrl: directed vectors, a transaction-level model
// compared every cycle, and hand-computed literal expectations.
module tb_rv32i_branch_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FC    = 2;
  localparam int unsigned CNT_W = 32;

  logic              clk_i = 1'b0;
  logic              reset;
  logic              valid_i, branch_i, jal_i, jalr_i;
  logic [2:0]        funct3_i;
  logic [XLEN-1:0]   pc_i, imm_i, alu_result_i;
  logic              equal_i, less_i, less_signed_i;
  logic              clear_o, busy_o, misalign_o, illegal_o;
  logic [CNT_W-1:0]  branch_cnt_o, redirect_cnt_o;

  int errors = 0;
  int checks = 0;

  rv32i_branch_ctrl_if #(.XLEN(XLEN)) rif ();

  rv32i_branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .reset          (reset),
    .valid_i        (valid_i),
    .branch_i       (branch_i),
    .jal_i          (jal_i),
    .jalr_i         (jalr_i),
    .funct3_i       (funct3_i),
    .pc_i           (pc_i),
    .imm_i          (imm_i),
    .alu_result_i   (alu_result_i),
    .equal_i        (equal_i),
    .less_i         (less_i),
    .less_signed_i  (less_signed_i),
    .redirect_if    (rif),
    .clear_o        (clear_o),
    .busy_o         (busy_o),
    .misalign_o     (misalign_o),
    .illegal_o      (illegal_o),
    .branch_cnt_o   (branch_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 = idle, 1 = offering redirect, 2 = flushing with m_left cycles to go
  bit          m_on = 1'b0;
  int          m_mode, m_left;
  logic        e_rv, e_clear, e_busy, e_mis, e_ill;
  logic [31:0] e_pc, e_bcnt, e_rcnt;
  logic [31:0] m_tgt;
  bit          m_taken;

  function automatic bit model_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic lts);
    case (f3)
      3'b000:  return eq;      // BEQ
      3'b001:  return !eq;     // BNE
      3'b100:  return lts;     // BLT
      3'b101:  return !lts;    // BGE
      3'b110:  return lt;      // BLTU
      3'b111:  return !lt;     // BGEU
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (reset) begin
      m_on = 1'b1; m_mode = 0; m_left = 0;
      e_rv = 0; e_clear = 0; e_busy = 0; e_mis = 0; e_ill = 0;
      e_pc = 0; e_bcnt = 0; e_rcnt = 0;
    end else if (m_on) begin
      e_mis = 0;
      e_ill = 0;
      if (m_mode == 0) begin
        if (valid_i) begin
          m_taken = 1'b0;
          if (jalr_i) begin
            m_tgt = alu_result_i & 32'hFFFF_FFFE;
            m_taken = 1'b1;
          end else if (jal_i) begin
            m_tgt = pc_i + imm_i;
            m_taken = 1'b1;
          end else if (branch_i) begin
            m_tgt = pc_i + imm_i;
            m_taken = model_taken(funct3_i, equal_i, less_i, less_signed_i);
            e_ill = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            e_bcnt = e_bcnt + 1;
          end
          if (m_taken) begin
            if (m_tgt[1]) e_mis = 1;
            else begin
              e_rv = 1; e_pc = m_tgt; e_clear = 1; m_mode = 1;
            end
          end
        end
      end else if (m_mode == 1) begin
        if (rif.ready) begin
          e_rv = 0; e_rcnt = e_rcnt + 1; m_mode = 2; m_left = FC;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 0; e_clear = 0;
        end
      end
      e_busy = (m_mode != 0);
    end
  end

  always @(negedge clk_i) begin
    if (m_on) begin
      chk("m_redirect_valid", 64'(rif.valid), 64'(e_rv));
      if (e_rv) chk("m_redirect_pc", 64'(rif.pc), 64'(e_pc));
      chk("m_clear", 64'(clear_o), 64'(e_clear));
      chk("m_busy", 64'(busy_o), 64'(e_busy));
      chk("m_misalign", 64'(misalign_o), 64'(e_mis));
      chk("m_illegal", 64'(illegal_o), 64'(e_ill));
      chk("m_branch_cnt", 64'(branch_cnt_o), 64'(e_bcnt));
      chk("m_redirect_cnt", 64'(redirect_cnt_o), 64'(e_rcnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    valid_i = 0; branch_i = 0; jal_i = 0; jalr_i = 0; funct3_i = 3'b000;
    pc_i = '0; imm_i = '0; alu_result_i = '0;
    equal_i = 0; less_i = 0; less_signed_i = 0;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                       input logic eq, input logic lt, input logic lts);
    valid_i = 1; branch_i = br; jal_i = jal; jalr_i = jalr; funct3_i = f3;
    pc_i = pc; imm_i = imm; alu_result_i = alu;
    equal_i = eq; less_i = lt; less_signed_i = lts;
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk_i); #1;
    reset = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk(name, 64'(busy_o), 64'd0);
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (clear_o && n < 100) begin
      n++;
      @(posedge clk_i); #1;
    end
  endtask

  logic [2:0] t7_f3  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       t7_exp [6] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0};

  initial begin
    int n, m;
    idle_inputs();
    rif.ready = 0;
    reset = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(rif.valid), 64'd0);
    chk("rst_clear", 64'(clear_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_branch_cnt", 64'(branch_cnt_o), 64'd0);
    chk("rst_redirect_cnt", 64'(redirect_cnt_o), 64'd0);
    reset = 0;

    // 1: BEQ taken, ready tied high
    rif.ready = 1;
    drive(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0, 0);
    chk("t1_valid", 64'(rif.valid), 64'd1);
    chk("t1_pc", 64'(rif.pc), 64'h120);
    count_clear(n);
    chk("t1_clear_cycles", 64'(n), 64'd3);
    chk("t1_redirect_cnt", 64'(redirect_cnt_o), 64'd1);
    chk("t1_branch_cnt", 64'(branch_cnt_o), 64'd1);

    // 2: BLTU not taken despite signed-less
    do_reset();
    drive(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'h0, 0, 0, 1);
    chk("t2_valid", 64'(rif.valid), 64'd0);
    chk("t2_busy", 64'(busy_o), 64'd0);
    chk("t2_branch_cnt", 64'(branch_cnt_o), 64'd1);
    chk("t2_redirect_cnt", 64'(redirect_cnt_o), 64'd0);

    // 3: JALR misaligned then aligned
    drive(0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h2003, 0, 0, 0);
    chk("t3_misalign", 64'(misalign_o), 64'd1);
    chk("t3_no_valid", 64'(rif.valid), 64'd0);
    @(posedge clk_i); #1;
    chk("t3_misalign_pulse", 64'(misalign_o), 64'd0);
    drive(0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h2001, 0, 0, 0);
    chk("t3_valid", 64'(rif.valid), 64'd1);
    chk("t3_pc", 64'(rif.pc), 64'h2000);
    wait_idle("t3_idle");

    // 4: JAL backwards with fetch stalled for 5 cycles
    do_reset();
    rif.ready = 0;
    drive(0, 1, 0, 3'b000, 32'h400, 32'hFFFF_FF00, 32'h0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_stable", 64'(rif.valid), 64'd1);
      chk("t4_pc_stable", 64'(rif.pc), 64'h300);
      if (clear_o) n++;
      @(posedge clk_i); #1;
    end
    rif.ready = 1;
    count_clear(m);
    chk("t4_clear_cycles", 64'(n + m), 64'd8);
    chk("t4_redirect_cnt", 64'(redirect_cnt_o), 64'd1);

    // 5: illegal funct3 pulse; wrong-path valids while busy are ignored
    do_reset();
    drive(1, 0, 0, 3'b010, 32'h100, 32'h20, 32'h0, 1, 1, 1);
    chk("t5_illegal", 64'(illegal_o), 64'd1);
    chk("t5_no_valid", 64'(rif.valid), 64'd0);
    @(posedge clk_i); #1;
    chk("t5_illegal_pulse", 64'(illegal_o), 64'd0);
    drive(1, 0, 0, 3'b001, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, 0, 0);
    chk("t5_wrap_pc", 64'(rif.pc), 64'h10);
    valid_i = 1; branch_i = 1; funct3_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk("t5_no_illegal_busy", 64'(illegal_o), 64'd0);
    end
    idle_inputs();
    chk("t5_idle", 64'(busy_o), 64'd0);
    chk("t5_branch_cnt", 64'(branch_cnt_o), 64'd2);
    chk("t5_redirect_cnt", 64'(redirect_cnt_o), 64'd1);

    // 6: reset in REDIRECT, then BNE resolves normally
    do_reset();
    rif.ready = 0;
    drive(0, 1, 0, 3'b000, 32'h40, 32'h10, 32'h0, 0, 0, 0);
    chk("t6_valid_before", 64'(rif.valid), 64'd1);
    reset = 1;
    @(posedge clk_i); #1;
    chk("t6_rst_valid", 64'(rif.valid), 64'd0);
    chk("t6_rst_clear", 64'(clear_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    reset = 0;
    rif.ready = 1;
    drive(1, 0, 0, 3'b001, 32'h80, 32'h8, 32'h0, 0, 0, 0);
    chk("t6_pc", 64'(rif.pc), 64'h88);
    wait_idle("t6_idle");
    chk("t6_branch_cnt", 64'(branch_cnt_o), 64'd1);
    chk("t6_redirect_cnt", 64'(redirect_cnt_o), 64'd1);

    // 7: every condition code with equal=0, less=1, less_signed=0
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, t7_f3[i], 32'h1000, 32'h40, 32'h0, 0, 1, 0);
      chk("t7_taken", 64'(rif.valid), 64'(t7_exp[i]));
      wait_idle("t7_idle");
    end

    // 8: JALR wins over JAL
    drive(0, 1, 1, 3'b000, 32'h0, 32'h40, 32'h500, 0, 0, 0);
    chk("t8_pc", 64'(rif.pc), 64'h500);
    wait_idle("t8_idle");

    @(posedge clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
